// File: rtl/tap_loader_if.sv
// Bundles the ioctl download port and the RAM port-B write/status signals of tap_loader.
interface tap_loader_if;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    logic              tap_sel;
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [DATA_W-1:0] ioctl_dout;

    logic [ADDR_W-1:0] tape_addr;
    logic [DATA_W-1:0] tape_dout;
    logic              tape_wr;
    logic              tape_complete;
    logic              tape_err;
    logic              autostart;
    logic              is_basic;
    logic [ADDR_W-1:0] load_start;
    logic [ADDR_W-1:0] load_end;

    modport master (
        output tap_sel, ioctl_download, ioctl_wr, ioctl_dout,
        input  tape_addr, tape_dout, tape_wr, tape_complete, tape_err,
               autostart, is_basic, load_start, load_end
    );

    modport slave (
        input  tap_sel, ioctl_download, ioctl_wr, ioctl_dout,
        output tape_addr, tape_dout, tape_wr, tape_complete, tape_err,
               autostart, is_basic, load_start, load_end
    );
endinterface

// File: rtl/tap_loader.sv
// Parses the first block of an Oric .TAP download and writes its payload into RAM port B.
module tap_loader #(
    parameter int unsigned MIN_SYNC = 3,
    parameter int unsigned MAX_NAME = 16
) (
    input  logic         clk_sys,
    input  logic         reset,
    tap_loader_if.slave  bus
);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = 4;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_HDR  = 3'd2;
    localparam logic [2:0] ST_NAME = 3'd3;
    localparam logic [2:0] ST_DATA = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;
    localparam logic [2:0] ST_ERR  = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  sync_cnt_q, sync_cnt_d;
    logic [IDX_W-1:0]  hdr_idx_q, hdr_idx_d;
    logic [CNT_W-1:0]  name_cnt_q, name_cnt_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [DATA_W-1:0] hdr_type_q, hdr_type_d;
    logic [DATA_W-1:0] hdr_auto_q, hdr_auto_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              wr_q, wr_d;
    logic              complete_q, complete_d;
    logic              err_q, err_d;
    logic              autostart_q, autostart_d;
    logic              is_basic_q, is_basic_d;
    logic [ADDR_W-1:0] load_start_q, load_start_d;
    logic [ADDR_W-1:0] load_end_q, load_end_d;
    logic              dl_prev;

    logic              dl_rise_c;
    logic              dl_fall_c;
    logic [DATA_W-1:0] din_c;

    assign dl_rise_c = bus.ioctl_download & ~dl_prev & bus.tap_sel;
    assign dl_fall_c = ~bus.ioctl_download & dl_prev;
    assign din_c     = bus.ioctl_dout;

    assign bus.tape_addr     = addr_q;
    assign bus.tape_dout     = dout_q;
    assign bus.tape_wr       = wr_q;
    assign bus.tape_complete = complete_q;
    assign bus.tape_err      = err_q;
    assign bus.autostart     = autostart_q;
    assign bus.is_basic      = is_basic_q;
    assign bus.load_start    = load_start_q;
    assign bus.load_end      = load_end_q;

    // Download level history; tracked through reset so a held download does not look like a new edge.
    always_ff @(posedge clk_sys) begin
        dl_prev <= bus.ioctl_download;
    end

    // State and output registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sync_cnt_q   <= '0;
            hdr_idx_q    <= '0;
            name_cnt_q   <= '0;
            cur_addr_q   <= '0;
            hdr_type_q   <= '0;
            hdr_auto_q   <= '0;
            addr_q       <= '0;
            dout_q       <= '0;
            wr_q         <= 1'b0;
            complete_q   <= 1'b0;
            err_q        <= 1'b0;
            autostart_q  <= 1'b0;
            is_basic_q   <= 1'b0;
            load_start_q <= '0;
            load_end_q   <= '0;
        end else begin
            state_q      <= state_d;
            sync_cnt_q   <= sync_cnt_d;
            hdr_idx_q    <= hdr_idx_d;
            name_cnt_q   <= name_cnt_d;
            cur_addr_q   <= cur_addr_d;
            hdr_type_q   <= hdr_type_d;
            hdr_auto_q   <= hdr_auto_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            wr_q         <= wr_d;
            complete_q   <= complete_d;
            err_q        <= err_d;
            autostart_q  <= autostart_d;
            is_basic_q   <= is_basic_d;
            load_start_q <= load_start_d;
            load_end_q   <= load_end_d;
        end
    end

    // Byte parser: next state, header capture and RAM write generation.
    always_comb begin
        state_d      = state_q;
        sync_cnt_d   = sync_cnt_q;
        hdr_idx_d    = hdr_idx_q;
        name_cnt_d   = name_cnt_q;
        cur_addr_d   = cur_addr_q;
        hdr_type_d   = hdr_type_q;
        hdr_auto_d   = hdr_auto_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        wr_d         = 1'b0;
        complete_d   = complete_q;
        err_d        = err_q;
        autostart_d  = autostart_q;
        is_basic_d   = is_basic_q;
        load_start_d = load_start_q;
        load_end_d   = load_end_q;

        if (bus.ioctl_wr) begin
            case (state_q)
                ST_SYNC: begin
                    if (din_c == 8'h16) begin
                        if (sync_cnt_q != 8'hFF) sync_cnt_d = sync_cnt_q + 8'd1;
                    end else if (din_c == 8'h24 && 32'(sync_cnt_q) >= MIN_SYNC) begin
                        state_d   = ST_HDR;
                        hdr_idx_d = '0;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
                ST_HDR: begin
                    hdr_idx_d = hdr_idx_q + 4'd1;
                    case (hdr_idx_q)
                        4'd2: hdr_type_d = din_c;
                        4'd3: hdr_auto_d = din_c;
                        4'd4: load_end_d[15:8]   = din_c;
                        4'd5: load_end_d[7:0]    = din_c;
                        4'd6: load_start_d[15:8] = din_c;
                        4'd7: load_start_d[7:0]  = din_c;
                        4'd8: begin
                            if (load_end_q < load_start_q) begin
                                state_d = ST_ERR;
                            end else begin
                                cur_addr_d = load_start_q;
                                state_d    = ST_NAME;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_NAME: begin
                    if (din_c == 8'h00) begin
                        state_d = ST_DATA;
                    end else if (32'(name_cnt_q) >= MAX_NAME) begin
                        state_d = ST_ERR;
                    end else begin
                        name_cnt_d = name_cnt_q + 8'd1;
                    end
                end
                ST_DATA: begin
                    wr_d   = 1'b1;
                    addr_d = cur_addr_q;
                    dout_d = din_c;
                    if (cur_addr_q == load_end_q) begin
                        state_d     = ST_DONE;
                        complete_d  = 1'b1;
                        autostart_d = (hdr_auto_q != 8'h00);
                        is_basic_d  = (hdr_type_q == 8'h00);
                    end else begin
                        cur_addr_d = cur_addr_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end

        // A dropped download truncates any unfinished block, after the last byte is processed.
        if (dl_fall_c && (state_d == ST_SYNC || state_d == ST_HDR ||
                          state_d == ST_NAME || state_d == ST_DATA)) begin
            state_d = ST_ERR;
        end

        if (state_d == ST_ERR) err_d = 1'b1;

        // A new accepted download overrides everything, including a byte in the same cycle.
        if (dl_rise_c) begin
            state_d      = ST_SYNC;
            sync_cnt_d   = '0;
            hdr_idx_d    = '0;
            name_cnt_d   = '0;
            wr_d         = 1'b0;
            complete_d   = 1'b0;
            err_d        = 1'b0;
            autostart_d  = 1'b0;
            is_basic_d   = 1'b0;
            load_start_d = '0;
            load_end_d   = '0;
        end
    end
endmodule
